// File: rtl/amba_packet_tx_if.sv
// Byte-wide packet link bundle between a packet transmitter and its environment.
// The master side drives requests, payload and backpressure. The slave side is the transmitter.
interface amba_packet_tx_if #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 6
);
    logic              start;
    logic [ADDR_W-1:0] dest;
    logic [LEN_W-1:0]  len;
    logic              err_inject;
    logic [7:0]        pl_data;
    logic              pl_valid;
    logic              pl_ready;
    logic              busy;
    logic [7:0]        data_out;
    logic              tx_valid;
    logic              pkt_valid;
    logic              idle;
    logic              done;
    logic              bad_req;

    modport master (
        output start, dest, len, err_inject, pl_data, pl_valid, busy,
        input  pl_ready, data_out, tx_valid, pkt_valid, idle, done, bad_req
    );

    modport slave (
        input  start, dest, len, err_inject, pl_data, pl_valid, busy,
        output pl_ready, data_out, tx_valid, pkt_valid, idle, done, bad_req
    );
endinterface

// File: rtl/amba_packet_tx.sv
// Packet transmitter: sends a header byte, then the payload bytes, then a trailing parity byte.
// It waits while the receiver asserts busy, and it can deliberately corrupt the parity byte.
//
// state     | meaning
// S_IDLE    | waiting for start; a start to the reserved destination pulses bad_req
// S_HEADER  | header {len,dest} on data_out until it is transferred
// S_PAYLOAD | pulls payload bytes from upstream; tx_valid=0 between bytes is a bubble
// S_PARITY  | parity byte on data_out with pkt_valid=0 until it is transferred
// S_DONE    | one-cycle done pulse, then back to idle
module amba_packet_tx #(
    parameter int                ADDR_W   = 2,
    parameter int                LEN_W    = 6,
    parameter logic [ADDR_W-1:0] BAD_ADDR = {ADDR_W{1'b1}}
) (
    input  logic            clock,
    input  logic            reset,
    amba_packet_tx_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PARITY, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         data_q, data_nxt;
    logic               tx_valid_q, tx_valid_nxt;
    logic               pkt_valid_q, pkt_valid_nxt;
    logic [7:0]         parity_q, parity_nxt;
    logic [LEN_W-1:0]   cnt_q, cnt_nxt;
    logic               err_q, err_nxt;
    logic               bad_q, bad_nxt;
    logic               pl_ready_c;
    logic               xfer;

    assign xfer = tx_valid_q && !bus.busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            data_q      <= 8'h00;
            tx_valid_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            parity_q    <= 8'h00;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            data_q      <= data_nxt;
            tx_valid_q  <= tx_valid_nxt;
            pkt_valid_q <= pkt_valid_nxt;
            parity_q    <= parity_nxt;
            cnt_q       <= cnt_nxt;
            err_q       <= err_nxt;
            bad_q       <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        data_nxt      = data_q;
        tx_valid_nxt  = tx_valid_q;
        pkt_valid_nxt = pkt_valid_q;
        parity_nxt    = parity_q;
        cnt_nxt       = cnt_q;
        err_nxt       = err_q;
        bad_nxt       = 1'b0;
        pl_ready_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.dest == BAD_ADDR) begin
                        bad_nxt = 1'b1;
                    end else begin
                        state_nxt     = S_HEADER;
                        data_nxt      = {bus.len, bus.dest};
                        tx_valid_nxt  = 1'b1;
                        pkt_valid_nxt = 1'b1;
                        parity_nxt    = {bus.len, bus.dest};
                        cnt_nxt       = bus.len;
                        err_nxt       = bus.err_inject;
                    end
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    if (cnt_q != '0) begin
                        state_nxt    = S_PAYLOAD;
                        tx_valid_nxt = 1'b0;
                    end else begin
                        state_nxt     = S_PARITY;
                        data_nxt      = parity_q ^ {7'b0, err_q};
                        pkt_valid_nxt = 1'b0;
                    end
                end
            end
            S_PAYLOAD: begin
                // A new byte may replace the current one in the cycle it is transferred.
                pl_ready_c = (cnt_q != '0) && (!tx_valid_q || !bus.busy);
                if (pl_ready_c && bus.pl_valid) begin
                    data_nxt     = bus.pl_data;
                    tx_valid_nxt = 1'b1;
                    parity_nxt   = parity_q ^ bus.pl_data;
                    cnt_nxt      = cnt_q - LEN_W'(1);
                end else if (xfer) begin
                    if (cnt_q == '0) begin
                        state_nxt     = S_PARITY;
                        data_nxt      = parity_q ^ {7'b0, err_q};
                        pkt_valid_nxt = 1'b0;
                    end else begin
                        tx_valid_nxt = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (xfer) begin
                    state_nxt    = S_DONE;
                    tx_valid_nxt = 1'b0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.pl_ready  = pl_ready_c;
    assign bus.data_out  = data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.idle      = (state == S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.bad_req   = bad_q;
endmodule

// File: tb/tb_amba_packet_tx.sv
// Scoreboard bench for amba_packet_tx. Directed packets push their expected byte, done and bad_req
// events. An independent monitor pops an event whenever the DUT transfers a byte or pulses done/bad_req.
module tb_amba_packet_tx;
    localparam int K_BYTE = 0;
    localparam int K_DONE = 1;
    localparam int K_BAD  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
        logic       pkv;
    } exp_t;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   base  = 0;
    logic acc   = 1'b0;
    exp_t sb[$];
    logic [7:0] pl_q[$];

    amba_packet_tx_if #(.ADDR_W(2), .LEN_W(6)) bus ();

    amba_packet_tx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc - base);
        end
    endfunction

    function automatic void push_byte(int c, logic [7:0] d, logic p);
        exp_t e;
        e.kind = K_BYTE; e.cyc = c; e.data = d; e.pkv = p;
        sb.push_back(e);
    endfunction

    function automatic void push_ev(int k, int c);
        exp_t e;
        e.kind = k; e.cyc = c; e.data = 8'h00; e.pkv = 1'b0;
        sb.push_back(e);
    endfunction

    function automatic void take(int kind, int rel);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d data 0x%0h, none expected", kind, rel, bus.data_out);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.cyc != rel ||
            (kind == K_BYTE && (e.data !== bus.data_out || e.pkv !== bus.pkt_valid))) begin
            bad++;
            $display("FAIL event: got kind %0d cycle %0d data 0x%0h pkt_valid %0b, expected kind %0d cycle %0d data 0x%0h pkt_valid %0b",
                     kind, rel, bus.data_out, bus.pkt_valid, e.kind, e.cyc, e.data, e.pkv);
        end
    endfunction

    // Monitor: consumes scoreboard entries and checks that held outputs stay stable under busy.
    initial begin
        logic       hold_p;
        logic [7:0] d_p;
        logic       pk_p;
        int         rel;
        hold_p = 1'b0;
        d_p    = 8'h00;
        pk_p   = 1'b0;
        forever begin
            @(negedge clock);
            rel = cyc - base;
            if (hold_p) begin
                chk("hold_data", bus.data_out, d_p);
                chk("hold_tx_valid", bus.tx_valid, 1);
                chk("hold_pkt_valid", bus.pkt_valid, pk_p);
            end
            if (bus.tx_valid && bus.busy) chk("no_accept_busy", bus.pl_ready, 0);
            hold_p = bus.tx_valid && bus.busy && !reset;
            d_p    = bus.data_out;
            pk_p   = bus.pkt_valid;
            if (bus.tx_valid && !bus.busy) take(K_BYTE, rel);
            if (bus.done) take(K_DONE, rel);
            if (bus.bad_req) take(K_BAD, rel);
        end
    end

    function automatic void drive_pl();
        bus.pl_valid = (pl_q.size() != 0);
        bus.pl_data  = (pl_q.size() != 0) ? pl_q[0] : 8'h00;
    endfunction

    task automatic to_neg();
        @(negedge clock);
        acc = bus.pl_valid && bus.pl_ready;
    endtask

    task automatic to_next();
        @(posedge clock);
        #1;
        if (acc && pl_q.size() != 0) void'(pl_q.pop_front());
        acc = 1'b0;
        drive_pl();
    endtask

    task automatic adv();
        to_neg();
        to_next();
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            adv();
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input logic e, input int start_n,
                           input int bf, input int bt, input int bub, input int idle_k);
        base = cyc;
        bus.dest       = d;
        bus.len        = l;
        bus.err_inject = e;
        drive_pl();
        for (int k = 0; k <= idle_k; k++) begin
            bus.start = (k < start_n);
            bus.busy  = (k >= bf && k <= bt);
            to_neg();
            if (k == bub) chk("bubble_tx_valid", bus.tx_valid, 0);
            if (k == idle_k - 1) chk("done_not_idle", bus.idle, 0);
            if (k == idle_k) chk("back_to_idle", bus.idle, 1);
            to_next();
        end
        bus.start = 1'b0;
        bus.busy  = 1'b0;
        drain();
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.dest       = '0;
        bus.len        = '0;
        bus.err_inject = 1'b0;
        bus.pl_data    = 8'h00;
        bus.pl_valid   = 1'b0;
        bus.busy       = 1'b0;
        to_next();
        to_next();
        to_neg();
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_pkt_valid", bus.pkt_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_bad_req", bus.bad_req, 0);
        chk("rst_idle", bus.idle, 1);
        chk("rst_pl_ready", bus.pl_ready, 0);
        reset = 1'b0;
        to_next();

        // dest=1 len=3, no backpressure
        pl_q = '{8'h11, 8'h22, 8'h33};
        push_byte(1, 8'h0D, 1); push_byte(3, 8'h11, 1); push_byte(4, 8'h22, 1);
        push_byte(5, 8'h33, 1); push_byte(6, 8'h0D, 0); push_ev(K_DONE, 7);
        run_pkt(2'd1, 6'd3, 1'b0, 1, -1, -1, 2, 8);

        // same packet, busy in cycles 4-6 holds 0x22
        pl_q = '{8'h11, 8'h22, 8'h33};
        push_byte(1, 8'h0D, 1); push_byte(3, 8'h11, 1); push_byte(7, 8'h22, 1);
        push_byte(8, 8'h33, 1); push_byte(9, 8'h0D, 0); push_ev(K_DONE, 10);
        run_pkt(2'd1, 6'd3, 1'b0, 1, 4, 6, 2, 11);

        // zero-length packet; start held into HEADER must be ignored
        push_byte(1, 8'h02, 1); push_byte(2, 8'h02, 0); push_ev(K_DONE, 3);
        run_pkt(2'd2, 6'd0, 1'b0, 2, -1, -1, -1, 4);

        // corrupted parity
        pl_q = '{8'h11, 8'h22, 8'h33};
        push_byte(1, 8'h0D, 1); push_byte(3, 8'h11, 1); push_byte(4, 8'h22, 1);
        push_byte(5, 8'h33, 1); push_byte(6, 8'h0C, 0); push_ev(K_DONE, 7);
        run_pkt(2'd1, 6'd3, 1'b1, 1, -1, -1, 2, 8);

        // reserved destination
        base = cyc;
        bus.dest  = 2'd3;
        bus.len   = 6'd5;
        bus.start = 1'b1;
        push_ev(K_BAD, 1);
        adv();
        bus.start = 1'b0;
        to_neg();
        chk("bad_tx_valid", bus.tx_valid, 0);
        chk("bad_idle", bus.idle, 1);
        to_next();
        adv();
        adv();
        to_neg();
        chk("bad_still_idle", bus.idle, 1);
        to_next();
        drain();

        // reset while the second payload byte is on data_out
        pl_q = '{8'h11, 8'h22, 8'h33};
        base = cyc;
        bus.dest       = 2'd1;
        bus.len        = 6'd3;
        bus.err_inject = 1'b0;
        drive_pl();
        push_byte(1, 8'h0D, 1); push_byte(3, 8'h11, 1); push_byte(4, 8'h22, 1);
        for (int k = 0; k < 4; k++) begin
            bus.start = (k == 0);
            adv();
        end
        reset = 1'b1;
        adv();
        reset = 1'b0;
        pl_q.delete();
        drive_pl();
        to_neg();
        chk("abort_tx_valid", bus.tx_valid, 0);
        chk("abort_pkt_valid", bus.pkt_valid, 0);
        chk("abort_data_out", bus.data_out, 0);
        chk("abort_idle", bus.idle, 1);
        chk("abort_done", bus.done, 0);
        to_next();
        drain();

        // fresh packet after the abort: dest=0 len=1 payload 0xFF
        pl_q = '{8'hFF};
        push_byte(1, 8'h04, 1); push_byte(3, 8'hFF, 1); push_byte(4, 8'hFB, 0); push_ev(K_DONE, 5);
        run_pkt(2'd0, 6'd1, 1'b0, 1, -1, -1, 2, 6);

        adv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/amba_packet_tx.md
Name: amba_packet_tx

Overview:
- Packet transmitter on the byte-wide packet interface; the source end of the link whose receiver computes header/data parity and flags err.
- Accepts a request (destination, length), emits a header byte, pulls payload bytes from an upstream source, then emits a trailing parity byte.
- Drives pkt_valid high for header and payload and low for the parity byte, honours receiver backpressure (busy), and can deliberately corrupt parity to exercise the receiver's err path.

Parameters:
- ADDR_W, 2, destination field width; header bits [ADDR_W-1:0].
- LEN_W, 6, payload length field width; header bits [7:ADDR_W]. ADDR_W+LEN_W must equal 8.
- BAD_ADDR, 2'b11, reserved destination; requests to it are rejected.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- start  in  1  request strobe, sampled only in IDLE
- dest  in  ADDR_W  destination, sampled with start
- len  in  LEN_W  payload byte count (0..2^LEN_W-1), sampled with start
- err_inject  in  1  sampled with start; 1 = transmitted parity byte XORed with 8'h01
- pl_data  in  8  payload byte from upstream
- pl_valid  in  1  pl_data valid
- pl_ready  out  1  combinational; payload accepted on a cycle with pl_valid && pl_ready
- busy  in  1  receiver backpressure; while high, the current byte is not consumed
- data_out  out  8  registered output byte
- tx_valid  out  1  registered; data_out holds a byte; transfer = tx_valid && !busy
- pkt_valid  out  1  registered; 1 for header/payload/bubbles, 0 for the parity byte and idle
- idle  out  1  1 in IDLE
- done  out  1  one-cycle pulse after the parity byte transfers
- bad_req  out  1  one-cycle pulse when start arrives with dest==BAD_ADDR

Behaviour:
- Reset: state IDLE; data_out=0, tx_valid=0, pkt_valid=0, done=0, bad_req=0, parity=0, counter=0, idle=1, pl_ready=0. Reset wins over every other event and aborts any packet in flight; the packet is not resumed.
- States: IDLE, HEADER, PAYLOAD, PARITY, DONE.
- IDLE:
  - start with dest!=BAD_ADDR: latch len, dest, err_inject; next cycle HEADER with data_out={len,dest}, tx_valid=1, pkt_valid=1, parity={len,dest}, counter=len.
  - start with dest==BAD_ADDR: stay IDLE, bad_req=1 for one cycle.
  - start outside IDLE is ignored.
- HEADER: hold outputs until transfer.
  - On transfer with len!=0: go to PAYLOAD, tx_valid=0 (one bubble cycle), pkt_valid stays 1.
  - On transfer with len==0: go to PARITY.
- PAYLOAD:
  - pl_ready = (counter!=0) && (!tx_valid || !busy).
  - On accept: data_out<=pl_data, tx_valid<=1, parity<=parity^pl_data, counter<=counter-1.
  - Else on transfer: tx_valid<=0. pkt_valid stays 1 during bubbles.
  - When counter==0 and the last payload byte transfers, go to PARITY in the same edge.
- PARITY entry: data_out<=parity^{7'b0,err_inject_latched}, tx_valid<=1, pkt_valid<=0. The parity byte follows the last payload byte back-to-back when busy is low. Hold until transfer.
- PARITY transfer: tx_valid<=0, go to DONE.
- DONE: done=1 for one cycle, then IDLE with idle=1. The earliest next start is accepted in the cycle after DONE.
- Parity: the XOR of the header and all payload bytes, computed on accept (not transfer). It is cleared only on reset and reloaded with the header at each start.
- Backpressure: data_out, tx_valid and pkt_valid are stable while busy=1. busy during a bubble (tx_valid=0) has no effect; acceptance continues.
- Maximum length: 2^LEN_W-1 bytes; the counter never wraps.

Test Plan:
- dest=1, len=3, payload 0x11,0x22,0x33 with pl_valid=1, busy=0, start in cycle 0 -> cycle1 data_out=0x0D pkt_valid=1; cycle2 bubble (tx_valid=0); cycles 3-5 show 0x11,0x22,0x33; cycle6 data_out=0x0D pkt_valid=0; cycle7 done=1; cycle8 idle=1.
- Same packet with busy=1 in cycles 4-6 -> 0x22 held on data_out in cycles 4-7 with no new pl_ready accept; 0x33 in cycle 8; parity 0x0D in cycle 9; done in cycle 10.
- dest=2, len=0 -> header 0x02 in cycle1; parity 0x02 with pkt_valid=0 in cycle2; done in cycle3.
- dest=1, len=3, err_inject=1 -> parity byte 0x0C; all other bytes as in the first scenario.
- start with dest=3 -> bad_req=1 for one cycle, tx_valid stays 0, idle stays 1; also assert start in HEADER -> ignored.
- reset asserted while the 2nd payload byte is on data_out -> next edge: tx_valid=0, pkt_valid=0, data_out=0, idle=1. A new start (dest=0, len=1, 0xFF) then gives header 0x04 and parity 0xFB.
